// File: rtl/i2c_register_target.sv
// I2C register target: address match, pointer write, auto-incrementing data writes and reads; open-drain SDA.
// Bus events act 3 i_clk cycles after the pin change; never stretches SCL, so there is no backpressure.
module i2c_register_target #(
    parameter logic [6:0] DEV_ADDR = 7'h40,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_low,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK, ST_WR_BYTE,
        ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE, ST_WAIT_STOP
    } state_t;

    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    logic [1:0] arm_q, arm_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_low_q, sda_low_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic       armed, scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0] shift_in;

    // Synchronizers reset to an idle bus; events stay masked until the
    // previous-value registers hold real samples, so reset never fakes START/STOP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            arm_q      <= 2'd0;
        end else begin
            scl_s1_q   <= i_scl;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= i_sda;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            arm_q      <= arm_d;
        end
    end

    always_comb begin
        arm_d = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end

    assign armed     = (arm_q == 2'd3);
    assign scl_rise  = armed &  scl_s2_q & ~scl_prev_q;
    assign scl_fall  = armed & ~scl_s2_q &  scl_prev_q;
    assign start_evt = armed & scl_s2_q & scl_prev_q &  sda_prev_q & ~sda_s2_q;
    assign stop_evt  = armed & scl_s2_q & scl_prev_q & ~sda_prev_q &  sda_s2_q;
    assign shift_in  = {shift_q[6:0], sda_s2_q};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            rw_q       <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_low_d  = sda_low_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (start_evt) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_evt) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        rw_d      = sda_s2_q;
                        if (shift_in[7:1] == DEV_ADDR && shift_in[7:1] != 7'd0) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // First fall drives the ACK low, second fall ends it.
                ST_ADDR_ACK, ST_REG_ACK: if (scl_fall) begin
                    if (!sda_low_q) begin
                        sda_low_d = 1'b1;
                    end else begin
                        sda_low_d = 1'b0;
                        if (state_q == ST_REG_ACK) begin
                            state_d = ST_WR_BYTE;
                        end else if (rw_q) begin
                            state_d   = ST_RD_BYTE;
                            shift_d   = i_rd_data;
                            sda_low_d = ~i_rd_data[7];
                            bit_cnt_d = 4'd0;
                            if (AUTO_INC) ptr_d = ptr_q + 8'd1;
                        end else begin
                            state_d = ST_REG;
                        end
                    end
                end
                ST_REG: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        ptr_d     = shift_in;
                        state_d   = ST_REG_ACK;
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = shift_q;
                        if (AUTO_INC) ptr_d = ptr_q + 8'd1;
                        sda_low_d  = 1'b1;
                        bit_cnt_d  = 4'd0;
                        state_d    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    sda_low_d = 1'b0;
                    state_d   = ST_WR_BYTE;
                end
                ST_RD_BYTE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            sda_low_d = ~shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                // A fall is only reached here after an ACK was sampled on the rise.
                ST_RD_ACK: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d   = ST_RD_BYTE;
                        shift_d   = i_rd_data;
                        sda_low_d = ~i_rd_data[7];
                        bit_cnt_d = 4'd0;
                        if (AUTO_INC) ptr_d = ptr_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda_low  = sda_low_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_rd_addr  = ptr_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_i2c_register_target.sv
// Directed bench: bit-banged I2C master on a wired-AND SDA, register file modelled as addr ^ 8'h3C.
module tb_i2c_register_target;

    localparam int Q = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       bus_sda;
    logic       o_sda_low, o_wr_valid, o_busy;
    logic [7:0] o_wr_addr, o_wr_data, o_rd_addr, i_rd_data;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int sda_low_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] log_a [32];
    logic [7:0] log_d [32];

    assign bus_sda   = m_sda & ~o_sda_low;
    assign i_rd_data = o_rd_addr ^ 8'h3C;

    always #5 i_clk = ~i_clk;

    i2c_register_target #(.DEV_ADDR(7'h40), .AUTO_INC(1'b1)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (m_scl),
        .i_sda      (bus_sda),
        .o_sda_low  (o_sda_low),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_busy     (o_busy)
    );

    always @(negedge i_clk) begin
        if (o_wr_valid) begin
            log_a[wr_cnt % 32] <= o_wr_addr;
            log_d[wr_cnt % 32] <= o_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (o_sda_low) sda_low_cnt <= sda_low_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_q();
        repeat (Q) step();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    // Leaves SDA just risen with SCL high; caller decides how long to wait.
    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1;
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; wait_q();
            m_scl = 1'b1; wait_q(); wait_q();
            m_scl = 1'b0; wait_q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        ack = bus_sda; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            m_scl = 1'b1; wait_q();
            b[i] = bus_sda; wait_q();
            m_scl = 1'b0;
        end
        m_sda = nack; wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
        m_sda = 1'b1;
    endtask

    logic       ack;
    logic [7:0] rb;
    int         base, lowc, busyc;

    initial begin
        repeat (4) step();
        chk("rst_sda_low", o_sda_low, 0);
        chk("rst_wr_valid", o_wr_valid, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_wr_data", o_wr_data, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_busy", o_busy, 0);
        i_rst_n = 1'b1;
        wait_q();

        // Single write, then STOP-to-idle latency.
        base = wr_cnt;
        i2c_start();
        write_byte(8'h80, ack); chk("t1_ack_addr", ack, 0);
        chk("t1_busy", o_busy, 1);
        write_byte(8'h00, ack); chk("t1_ack_reg", ack, 0);
        write_byte(8'h10, ack); chk("t1_ack_dat", ack, 0);
        i2c_stop();
        step(); step();
        chk("t1_busy_pre", o_busy, 1);
        step();
        chk("t1_busy_post", o_busy, 0);
        wait_q();
        chk("t1_strobes", wr_cnt - base, 1);
        chk("t1_addr", log_a[base % 32], 8'h00);
        chk("t1_data", log_d[base % 32], 8'h10);

        // Burst with auto-increment.
        base = wr_cnt;
        i2c_start();
        write_byte(8'h80, ack); chk("t2_ack_addr", ack, 0);
        write_byte(8'h06, ack); chk("t2_ack_reg", ack, 0);
        write_byte(8'h00, ack); chk("t2_ack_d0", ack, 0);
        write_byte(8'h00, ack); chk("t2_ack_d1", ack, 0);
        write_byte(8'h00, ack); chk("t2_ack_d2", ack, 0);
        write_byte(8'hD8, ack); chk("t2_ack_d3", ack, 0);
        i2c_stop(); wait_q();
        chk("t2_strobes", wr_cnt - base, 4);
        chk("t2_addr0", log_a[(base + 0) % 32], 8'h06);
        chk("t2_addr1", log_a[(base + 1) % 32], 8'h07);
        chk("t2_addr2", log_a[(base + 2) % 32], 8'h08);
        chk("t2_addr3", log_a[(base + 3) % 32], 8'h09);
        chk("t2_data0", log_d[(base + 0) % 32], 8'h00);
        chk("t2_data3", log_d[(base + 3) % 32], 8'hD8);

        // Foreign address ignored, then repeated START to our address.
        base = wr_cnt; lowc = sda_low_cnt; busyc = busy_cnt;
        i2c_start();
        write_byte(8'h82, ack); chk("t3_nack_addr", ack, 1);
        write_byte(8'h55, ack); chk("t3_nack_dat", ack, 1);
        chk("t3_sda_never_low", sda_low_cnt - lowc, 0);
        chk("t3_busy_never", busy_cnt - busyc, 0);
        chk("t3_no_strobe", wr_cnt - base, 0);
        i2c_start();
        write_byte(8'h80, ack); chk("t3_ack_addr", ack, 0);
        chk("t3_busy", o_busy, 1);
        write_byte(8'h01, ack); chk("t3_ack_reg", ack, 0);
        write_byte(8'h33, ack); chk("t3_ack_dat", ack, 0);
        i2c_stop(); wait_q();
        chk("t3_strobes", wr_cnt - base, 1);
        chk("t3_addr", log_a[base % 32], 8'h01);
        chk("t3_data", log_d[base % 32], 8'h33);

        // Pointer set, repeated START read of two bytes across the wrap.
        i2c_start();
        write_byte(8'h80, ack); chk("t4_ack_addr", ack, 0);
        write_byte(8'hFE, ack); chk("t4_ack_reg", ack, 0);
        chk("t4_ptr_fe", o_rd_addr, 8'hFE);
        i2c_start();
        write_byte(8'h81, ack); chk("t4_ack_rd", ack, 0);
        chk("t4_ptr_ff", o_rd_addr, 8'hFF);
        read_byte(1'b0, rb); chk("t4_rd0", rb, 8'hC2);
        chk("t4_ptr_wrap", o_rd_addr, 8'h00);
        read_byte(1'b1, rb); chk("t4_rd1", rb, 8'hC3);
        wait_q();
        chk("t4_released", o_sda_low, 0);
        chk("t4_ptr_hold", o_rd_addr, 8'h00);
        i2c_stop(); wait_q();
        chk("t4_busy", o_busy, 0);

        // Partial data byte aborted by STOP.
        base = wr_cnt;
        i2c_start();
        write_byte(8'h80, ack); chk("t5_ack_addr", ack, 0);
        write_byte(8'h09, ack); chk("t5_ack_reg", ack, 0);
        write_bits(8'hA0, 4);
        i2c_stop(); wait_q();
        chk("t5_no_strobe", wr_cnt - base, 0);
        chk("t5_released", o_sda_low, 0);
        chk("t5_busy", o_busy, 0);

        // Reset while driving the address ACK.
        i2c_start();
        write_bits(8'h80, 8);
        m_sda = 1'b1;
        chk("t6_ack_driven", o_sda_low, 1);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_release", o_sda_low, 0);
        repeat (3) step();
        i_rst_n = 1'b1;
        wait_q();
        chk("t6_ptr_reset", o_rd_addr, 8'h00);
        chk("t6_busy_reset", o_busy, 0);
        base = wr_cnt;
        i2c_start();
        write_byte(8'h80, ack); chk("t6_ack_addr", ack, 0);
        write_byte(8'h20, ack); chk("t6_ack_reg", ack, 0);
        write_byte(8'h5A, ack); chk("t6_ack_dat", ack, 0);
        i2c_stop(); wait_q();
        chk("t6_strobes", wr_cnt - base, 1);
        chk("t6_addr", log_a[base % 32], 8'h20);
        chk("t6_data", log_d[base % 32], 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
